// File: rtl/ppu_pkg.sv
// ppu_pkg: shared FSM state and grant encodings for the PPU feed arbiter
package ppu_pkg;
   typedef enum logic [1:0] {IDLE, ISSUE, RESP, EVAL} state_t;
   localparam logic [1:0] GNT_NONE = 2'b00;
   localparam logic [1:0] GNT_REQ0 = 2'b01;
   localparam logic [1:0] GNT_REQ1 = 2'b10;
   localparam int PPU_DATA_W = 8;
endpackage

// File: rtl/ppu_rr_pick.sv
// ppu_rr_pick: 2-way round-robin picker, line_pending forces req0 when it is requesting
module ppu_rr_pick import ppu_pkg::*; (
   input  logic [1:0] stb,
   input  logic       rr_ptr,
   input  logic       line_pending,
   output logic [1:0] win
);
   always_comb
      win = (line_pending && stb[0]) ? GNT_REQ0 :
            rr_ptr ? (stb[1] ? GNT_REQ1 : stb[0] ? GNT_REQ0 : GNT_NONE)
                   : (stb[0] ? GNT_REQ0 : stb[1] ? GNT_REQ1 : GNT_NONE);
endmodule

// File: rtl/ppu_feed_arb.sv
// ppu_feed_arb: burst-locked round-robin arbiter feeding the PPU byte port.
// Define PPU_FEED_TIMEOUT_EN to add the ISSUE ack-wait timeout and sticky err flag.
module ppu_feed_arb import ppu_pkg::*; #(
   parameter int BURST_LEN   = 32,
   parameter int DATA_W      = PPU_DATA_W,
   parameter int TIMEOUT_CYC = 255
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              sync,
   input  logic [DATA_W-1:0] req0_data,
   input  logic              req0_stb,
   output logic              req0_ack,
   input  logic [DATA_W-1:0] req1_data,
   input  logic              req1_stb,
   output logic              req1_ack,
   output logic [DATA_W-1:0] ppu_data,
   output logic              ppu_stb,
   input  logic              ppu_ack,
   output logic [1:0]        grant,
   output logic              busy,
   output logic              err
);
   localparam int BW = $clog2(BURST_LEN + 1);
   if (BURST_LEN < 1 || BURST_LEN > 255 || TIMEOUT_CYC < 1) begin : g_bad_cfg
      $error("ppu_feed_arb: parameter out of range");
   end
   state_t            state, state_n;
   logic [1:0]        grant_n, win;
   logic [DATA_W-1:0] data_n, win_data;
   logic [BW-1:0]     beats, beats_n;
   logic              stb_n, ack0_n, ack1_n, err_n;
   logic              rr_ptr, rr_n, line_pending, lp_n, sync_q, win_stb, release_now;
`ifdef PPU_FEED_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT_CYC + 1);
   logic [TW-1:0] wcnt, wcnt_n;
`endif
   ppu_rr_pick u_pick (
      .stb          ({req1_stb, req0_stb}),
      .rr_ptr       (rr_ptr),
      .line_pending (line_pending),
      .win          (win)
   );
   assign busy     = state != IDLE;
   assign win_stb  = grant == GNT_REQ1 ? req1_stb : req0_stb;
   assign win_data = grant == GNT_REQ1 ? req1_data : req0_data;
   // preemption by a pending line start only ever targets a req1 burst
   assign release_now = beats == BW'(BURST_LEN) || !win_stb || (line_pending && grant == GNT_REQ1);
   always_comb begin
      state_n = state;
      grant_n = grant;
      data_n  = ppu_data;
      stb_n   = ppu_stb;
      ack0_n  = 1'b0;
      ack1_n  = 1'b0;
      beats_n = beats;
      rr_n    = rr_ptr;
      lp_n    = line_pending;
      err_n   = err;
`ifdef PPU_FEED_TIMEOUT_EN
      wcnt_n  = '0;
`endif
      unique case (state)
         IDLE: if (win != GNT_NONE) begin
            state_n = ISSUE;
            grant_n = win;
            data_n  = win == GNT_REQ1 ? req1_data : req0_data;
            stb_n   = 1'b1;
            beats_n = '0;
            lp_n    = win == GNT_REQ0 ? 1'b0 : line_pending;
         end
         ISSUE: if (ppu_ack) begin
            state_n = RESP;
            stb_n   = 1'b0;
            ack0_n  = grant == GNT_REQ0;
            ack1_n  = grant == GNT_REQ1;
            beats_n = beats + 1'b1;
         end
`ifdef PPU_FEED_TIMEOUT_EN
         else if (wcnt == TW'(TIMEOUT_CYC - 1)) begin
            state_n = IDLE;
            stb_n   = 1'b0;
            data_n  = '0;
            err_n   = 1'b1;
            grant_n = GNT_NONE;
            rr_n    = grant == GNT_REQ0;
         end else wcnt_n = wcnt + 1'b1;
`endif
         RESP: state_n = EVAL;
         EVAL: if (release_now) begin
            state_n = IDLE;
            grant_n = GNT_NONE;
            data_n  = '0;
            rr_n    = grant == GNT_REQ0;
         end else begin
            state_n = ISSUE;
            data_n  = win_data;
            stb_n   = 1'b1;
         end
         default: state_n = IDLE;
      endcase
      // a sync edge coinciding with a req0 grant survives to the next decision
      if (sync && !sync_q) lp_n = 1'b1;
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= IDLE;
         grant        <= GNT_NONE;
         ppu_data     <= '0;
         ppu_stb      <= 1'b0;
         req0_ack     <= 1'b0;
         req1_ack     <= 1'b0;
         beats        <= '0;
         rr_ptr       <= 1'b0;
         line_pending <= 1'b0;
         sync_q       <= 1'b0;
         err          <= 1'b0;
      end else begin
         state        <= state_n;
         grant        <= grant_n;
         ppu_data     <= data_n;
         ppu_stb      <= stb_n;
         req0_ack     <= ack0_n;
         req1_ack     <= ack1_n;
         beats        <= beats_n;
         rr_ptr       <= rr_n;
         line_pending <= lp_n;
         sync_q       <= sync;
         err          <= err_n;
      end
   end
`ifdef PPU_FEED_TIMEOUT_EN
   always_ff @(posedge clk) wcnt <= rst ? '0 : wcnt_n;
`endif
endmodule

// File: tb/tb_ppu_feed_arb.sv
// tb_ppu_feed_arb: directed table and sequence checks for ppu_feed_arb (BURST_LEN=4, TIMEOUT_CYC=16)
module tb_ppu_feed_arb;
   import ppu_pkg::*;
   localparam int BL = 4;
   localparam int TO = 16;
   logic       clk = 1'b0, rst, sync, req0_stb, req1_stb, ppu_ack;
   logic [7:0] req0_data, req1_data, ppu_data;
   logic       req0_ack, req1_ack, ppu_stb, busy, err;
   logic [1:0] grant;
   int n_run = 0, n_fail = 0;
   always #5 clk = ~clk;
   ppu_feed_arb #(.BURST_LEN(BL), .DATA_W(8), .TIMEOUT_CYC(TO)) dut (
      .clk(clk), .rst(rst), .sync(sync),
      .req0_data(req0_data), .req0_stb(req0_stb), .req0_ack(req0_ack),
      .req1_data(req1_data), .req1_stb(req1_stb), .req1_ack(req1_ack),
      .ppu_data(ppu_data), .ppu_stb(ppu_stb), .ppu_ack(ppu_ack),
      .grant(grant), .busy(busy), .err(err)
   );
   typedef struct {
      logic [7:0] d0;
      logic       s0;
      logic       ack;
      logic [7:0] e_data;
      logic       e_stb, e_a0, e_a1;
      logic [1:0] e_gnt;
      logic       e_busy;
   } vec_t;
   vec_t tbl[24];
   function automatic vec_t mk(input logic [7:0] d0, input logic s0, input logic ack,
                               input logic [7:0] ed, input logic es, input logic ea0,
                               input logic [1:0] eg, input logic eb);
      vec_t v;
      v.d0 = d0; v.s0 = s0; v.ack = ack;
      v.e_data = ed; v.e_stb = es; v.e_a0 = ea0; v.e_a1 = 1'b0; v.e_gnt = eg; v.e_busy = eb;
      return v;
   endfunction
   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_run++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask
   task automatic step;
      @(posedge clk);
      #1;
   endtask
   task automatic do_reset;
      rst = 1'b1; sync = 1'b0; req0_stb = 1'b0; req1_stb = 1'b0; ppu_ack = 1'b0;
      req0_data = '0; req1_data = '0;
      step;
      step;
      rst = 1'b0;
   endtask
   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end
   initial begin
      int who[$];
      int idle, acks1, hi, acked;
      logic [7:0] d0, d1;
      logic [1:0] new_gnt;
      logic synced;
      // test 1: three req0 bytes, ack one cycle after stb
      tbl[0]  = mk(8'hA1, 1, 0, 8'hA1, 1, 0, GNT_REQ0, 1);
      tbl[1]  = mk(8'hA1, 1, 1, 8'hA1, 0, 1, GNT_REQ0, 1);
      tbl[2]  = mk(8'hA2, 1, 0, 8'hA1, 0, 0, GNT_REQ0, 1);
      tbl[3]  = mk(8'hA2, 1, 0, 8'hA2, 1, 0, GNT_REQ0, 1);
      tbl[4]  = mk(8'hA2, 1, 1, 8'hA2, 0, 1, GNT_REQ0, 1);
      tbl[5]  = mk(8'hA3, 1, 0, 8'hA2, 0, 0, GNT_REQ0, 1);
      tbl[6]  = mk(8'hA3, 1, 0, 8'hA3, 1, 0, GNT_REQ0, 1);
      tbl[7]  = mk(8'hA3, 1, 1, 8'hA3, 0, 1, GNT_REQ0, 1);
      tbl[8]  = mk(8'h00, 0, 0, 8'hA3, 0, 0, GNT_REQ0, 1);
      tbl[9]  = mk(8'h00, 0, 0, 8'h00, 0, 0, GNT_NONE, 0);
      // test 4: ack withheld for 10 cycles
      tbl[10] = mk(8'h55, 1, 0, 8'h55, 1, 0, GNT_REQ0, 1);
      for (int i = 11; i <= 20; i++) tbl[i] = mk(8'h55, 1, 0, 8'h55, 1, 0, GNT_REQ0, 1);
      tbl[21] = mk(8'h55, 1, 1, 8'h55, 0, 1, GNT_REQ0, 1);
      tbl[22] = mk(8'h00, 0, 0, 8'h55, 0, 0, GNT_REQ0, 1);
      tbl[23] = mk(8'h00, 0, 0, 8'h00, 0, 0, GNT_NONE, 0);
      do_reset;
      chk("rst_outputs", {ppu_data, ppu_stb, req0_ack, req1_ack, grant, busy, err}, 32'h0);
      for (int i = 0; i < 24; i++) begin
         req0_data = tbl[i].d0; req0_stb = tbl[i].s0; ppu_ack = tbl[i].ack;
         step;
         chk($sformatf("vec%0d_data", i), ppu_data, tbl[i].e_data);
         chk($sformatf("vec%0d_stb", i), ppu_stb, tbl[i].e_stb);
         chk($sformatf("vec%0d_ack", i), {req1_ack, req0_ack}, {tbl[i].e_a1, tbl[i].e_a0});
         chk($sformatf("vec%0d_grant", i), grant, tbl[i].e_gnt);
         chk($sformatf("vec%0d_busy", i), busy, tbl[i].e_busy);
      end
      chk("err_default", err, 1'b0);
      // test 2: both requesters saturated, bursts of BL alternate starting with req0
      do_reset;
      d0 = 8'h10; d1 = 8'h20;
      req0_data = d0; req1_data = d1; req0_stb = 1'b1; req1_stb = 1'b1;
      idle = 0;
      for (int c = 0; c < 200 && who.size() < 3 * BL; c++) begin
         step;
         if (req0_ack) begin who.push_back(0); d0++; req0_data = d0; end
         if (req1_ack) begin who.push_back(1); d1++; req1_data = d1; end
         if (!busy) idle++;
         if (ppu_stb) begin
            chk("t2_grant", grant, ((who.size() / BL) % 2) ? GNT_REQ1 : GNT_REQ0);
            chk("t2_data", ppu_data, ((who.size() / BL) % 2) ? d1 : d0);
         end
         ppu_ack = ppu_stb;
      end
      chk("t2_beats", who.size(), 3 * BL);
      for (int i = 0; i < who.size(); i++) chk($sformatf("t2_owner%0d", i), who[i], (i / BL) % 2);
      chk("t2_idle_gaps", idle, 2);
      // test 3: sync during req1 beat 2 preempts after that beat
      do_reset;
      d1 = 8'h30; req1_data = d1; req1_stb = 1'b1; req0_data = 8'h40;
      acks1 = 0; synced = 1'b0; new_gnt = GNT_NONE;
      for (int c = 0; c < 100; c++) begin
         step;
         if (req1_ack) begin acks1++; d1++; req1_data = d1; end
         if (!synced && ppu_stb && acks1 == 1) begin sync = 1'b1; req0_stb = 1'b1; synced = 1'b1; end
         if (synced && grant != GNT_REQ1 && grant != GNT_NONE) begin new_gnt = grant; break; end
         ppu_ack = ppu_stb;
      end
      chk("t3_req1_beats", acks1, 2);
      chk("t3_next_grant", new_gnt, GNT_REQ0);
      chk("t3_next_data", ppu_data, 8'h40);
      // test 5: reset in ISSUE drops the beat, then req0 wins first
      do_reset;
      req0_data = 8'h77; req0_stb = 1'b1; req1_data = 8'h88;
      step;
      chk("t5_issue_stb", ppu_stb, 1'b1);
      rst = 1'b1; ppu_ack = 1'b1;
      step;
      chk("t5_rst_out", {ppu_stb, grant, busy, req0_ack, req1_ack}, 32'h0);
      rst = 1'b0; ppu_ack = 1'b0; req1_stb = 1'b1;
      step;
      chk("t5_regrant", grant, GNT_REQ0);
      chk("t5_regrant_data", ppu_data, 8'h77);
      step;
      chk("t5_no_ack", {req1_ack, req0_ack}, 2'b00);
`ifdef PPU_FEED_TIMEOUT_EN
      // test 6: ppu_ack held low, timeout after TO cycles
      do_reset;
      req0_data = 8'h99; req0_stb = 1'b1; hi = 0; acked = 0;
      for (int c = 0; c < 60; c++) begin
         step;
         if (req0_ack) acked++;
         if (ppu_stb) hi++;
         else if (hi > 0) break;
      end
      chk("t6_stb_cycles", hi, TO);
      chk("t6_err", err, 1'b1);
      chk("t6_no_ack", acked, 0);
      step;
      chk("t6_regrant", {grant, ppu_stb}, {GNT_REQ0, 1'b1});
      chk("t6_err_sticky", err, 1'b1);
`endif
      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end
endmodule
